trng_req_arbiter: RTL and testbench

Shares the post-processed 32-bit random word stream among NUM_REQ consumers. Buffers incoming words in a small FIFO and grants them round-robin, one word per grant. Runs a repetition-count health test on ingress. On failure it flushes the buffer, blocks delivery and pulses a retune request toward the DCM tuning logic. Sits between the post-processing stage and the consumers, on the same clock as the TRNG core.

---
 rtl/trng_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_trng_req_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_req_arbiter.sv
// trng_req_arbiter: buffers health-tested random words and hands them out
// round-robin to NUM_REQ consumers, one word per one-cycle grant.
module trng_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int REP_LIMIT  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rnd_valid,
  input  logic [31:0]                   rnd_data,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [31:0]                   rsp_data,
  output logic                          rsp_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  input  logic                          health_clr,
  output logic                          retune_req,
  output logic [15:0]                   overflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(NUM_REQ);

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [31:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      fifo_level_q, fifo_level_d;
  logic [31:0]        last_word_q, last_word_d;
  logic               last_valid_q, last_valid_d;
  logic [3:0]         rep_cnt_q, rep_cnt_d;
  logic               health_fail_q, health_fail_d;
  logic               retune_req_q, retune_req_d;
  logic [15:0]        overflow_cnt_q, overflow_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]      last_gnt_q, last_gnt_d;

  logic [3:0]         cand_cnt_s;
  logic               fail_s;
  logic               pass_s;
  logic               push_s;
  logic               drop_s;
  logic               grant_s;
  logic               found_s;
  logic [IW-1:0]      rr_idx_s;
  logic [IW-1:0]      sel_idx_s;

  // Repetition-count health test on the incoming word (count saturates at 15).
  always_comb begin
    cand_cnt_s = 4'd1;
    if (last_valid_q && (rnd_data == last_word_q)) begin
      cand_cnt_s = (rep_cnt_q == 4'hF) ? 4'hF : rep_cnt_q + 4'd1;
    end else begin
      cand_cnt_s = 4'd1;
    end
    fail_s = rnd_valid && (cand_cnt_s >= 4'(REP_LIMIT));
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = last_gnt_q;
    rr_idx_s  = last_gnt_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx_s = IW'((int'(last_gnt_q) + i) % NUM_REQ);
      if (!found_s && req[rr_idx_s]) begin
        found_s   = 1'b1;
        sel_idx_s = rr_idx_s;
      end else begin
        found_s   = found_s;
      end
    end
    grant_s = !health_fail_q && (fifo_level_q != {LW{1'b0}}) && found_s;
  end

  // Next-state for FIFO, health state, grant outputs and overflow counter.
  always_comb begin
    pass_s = rnd_valid && !fail_s && !health_fail_q;
    push_s = pass_s && ((fifo_level_q != LW'(FIFO_DEPTH)) || grant_s);
    drop_s = pass_s && !push_s;

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = rnd_data;
    end else begin
      mem_d = mem_q;
    end

    wr_ptr_d = push_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = grant_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, grant_s})
      2'b10:   fifo_level_d = fifo_level_q + LW'(1);
      2'b01:   fifo_level_d = fifo_level_q - LW'(1);
      default: fifo_level_d = fifo_level_q;
    endcase
    // A failure empties the buffer; a grant in the same cycle still uses the head.
    if (fail_s) begin
      wr_ptr_d     = {AW{1'b0}};
      rd_ptr_d     = {AW{1'b0}};
      fifo_level_d = {LW{1'b0}};
    end else begin
      fifo_level_d = fifo_level_d;
    end

    gnt_d       = grant_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s) : {NUM_REQ{1'b0}};
    rsp_valid_d = grant_s;
    rsp_data_d  = grant_s ? mem_q[rd_ptr_q] : rsp_data_q;
    last_gnt_d  = grant_s ? sel_idx_s : last_gnt_q;

    // Failure beats a coincident clear, and retune only fires on a fresh failure.
    retune_req_d = fail_s && (!health_fail_q || health_clr);
    if (fail_s) begin
      health_fail_d = 1'b1;
    end else if (health_clr) begin
      health_fail_d = 1'b0;
    end else begin
      health_fail_d = health_fail_q;
    end

    last_word_d  = rnd_valid ? rnd_data   : last_word_q;
    last_valid_d = rnd_valid ? 1'b1       : last_valid_q;
    rep_cnt_d    = rnd_valid ? cand_cnt_s : rep_cnt_q;
    if (health_clr) begin
      last_valid_d = 1'b0;
      rep_cnt_d    = 4'd0;
    end else begin
      last_valid_d = last_valid_d;
    end

    overflow_cnt_d = (drop_s && (overflow_cnt_q != 16'hFFFF)) ? overflow_cnt_q + 16'd1
                                                             : overflow_cnt_q;
  end

  // State registers with synchronous reset; requester 0 gets first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      fifo_level_q   <= {LW{1'b0}};
      last_word_q    <= 32'h0;
      last_valid_q   <= 1'b0;
      rep_cnt_q      <= 4'd0;
      health_fail_q  <= 1'b0;
      retune_req_q   <= 1'b0;
      overflow_cnt_q <= 16'h0;
      gnt_q          <= {NUM_REQ{1'b0}};
      rsp_data_q     <= 32'h0;
      rsp_valid_q    <= 1'b0;
      last_gnt_q     <= IW'(NUM_REQ - 1);
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_level_q   <= fifo_level_d;
      last_word_q    <= last_word_d;
      last_valid_q   <= last_valid_d;
      rep_cnt_q      <= rep_cnt_d;
      health_fail_q  <= health_fail_d;
      retune_req_q   <= retune_req_d;
      overflow_cnt_q <= overflow_cnt_d;
      gnt_q          <= gnt_d;
      rsp_data_q     <= rsp_data_d;
      rsp_valid_q    <= rsp_valid_d;
      last_gnt_q     <= last_gnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign fifo_level   = fifo_level_q;
  assign health_fail  = health_fail_q;
  assign retune_req   = retune_req_q;
  assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_trng_req_arbiter.sv
// Bench for trng_req_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based behavioural model.
module tb_trng_req_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int REP_LIMIT  = 3;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int VW         = NUM_REQ + 1 + 32 + LW + 1 + 1 + 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rnd_valid = 1'b0;
  logic [31:0]        rnd_data = 32'h0;
  logic [NUM_REQ-1:0] req = '0;
  logic               health_clr = 1'b0;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        rsp_data;
  logic               rsp_valid;
  logic [LW-1:0]      fifo_level;
  logic               health_fail;
  logic               retune_req;
  logic [15:0]        overflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  trng_req_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst(rst), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .req(req),
    .gnt(gnt), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .fifo_level(fifo_level),
    .health_fail(health_fail), .health_clr(health_clr), .retune_req(retune_req),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_vec = {gnt, rsp_valid, rsp_data, fifo_level, health_fail, retune_req, overflow_cnt};

  // Behavioural model: word queue, repeat counter, sticky flag, rotation index.
  logic [31:0]        mq[$];
  logic [31:0]        m_last_word;
  bit                 m_last_valid;
  int                 m_rep;
  bit                 m_hf;
  bit                 m_retune;
  int                 m_ovf;
  int                 m_last_gnt;
  logic [NUM_REQ-1:0] m_gnt;
  bit                 m_rsp_valid;
  logic [31:0]        m_rsp_data;

  function automatic logic [VW-1:0] model_vec();
    return {m_gnt, m_rsp_valid, m_rsp_data, LW'(mq.size()), m_hf, m_retune, 16'(m_ovf)};
  endfunction

  task automatic model_step();
    bit grant;
    int win;
    bit fail;
    int cand;
    bit accept;
    bit full;
    if (rst) begin
      mq.delete();
      m_last_word = 32'h0; m_last_valid = 0; m_rep = 0; m_hf = 0; m_retune = 0;
      m_ovf = 0; m_last_gnt = NUM_REQ - 1; m_gnt = '0; m_rsp_valid = 0; m_rsp_data = 32'h0;
      return;
    end
    grant = 0;
    win = 0;
    if (!m_hf && mq.size() > 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant && req[(m_last_gnt + k) % NUM_REQ]) begin
          grant = 1;
          win = (m_last_gnt + k) % NUM_REQ;
        end
      end
    end
    fail = 0;
    if (rnd_valid) begin
      cand = (m_last_valid && rnd_data == m_last_word) ? ((m_rep < 15) ? m_rep + 1 : 15) : 1;
      fail = (cand >= REP_LIMIT);
      m_last_word = rnd_data;
      m_last_valid = 1;
      m_rep = cand;
    end
    accept = rnd_valid && !fail && !m_hf;
    full = (mq.size() == FIFO_DEPTH);
    m_gnt = grant ? NUM_REQ'(1 << win) : '0;
    m_rsp_valid = grant;
    if (grant) begin
      m_rsp_data = mq[0];
      void'(mq.pop_front());
      m_last_gnt = win;
    end
    if (accept) begin
      if (!full || grant) mq.push_back(rnd_data);
      else if (m_ovf < 65535) m_ovf++;
    end
    if (fail) mq.delete();
    m_retune = fail && (!m_hf || health_clr);
    if (fail) m_hf = 1;
    else if (health_clr) m_hf = 0;
    if (health_clr) begin
      m_rep = 0;
      m_last_valid = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rnd_valid = 1'b0; req = '0; health_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    rnd_valid = 1'b1;
    rnd_data = w;
    step();
    rnd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec, {VW{1'b0}});
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 3; i++) push_word(32'(i + 1));
    vectors++;
    if (fifo_level !== LW'(3)) begin
      miscompares++;
      $display("FAIL fill_level: got %0d want 3", fifo_level);
    end
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (i < 3) begin
        if (gnt !== 4'b0001 || rsp_data !== 32'(i + 1) || fifo_level !== LW'(2 - i) || dut_vec !== model_vec()) begin
          miscompares++;
          $display("FAIL drain_%0d: got gnt=%b data=%h lvl=%0d want gnt=0001 data=%h lvl=%0d", i, gnt, rsp_data, fifo_level, i + 1, 2 - i);
        end
      end else begin
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || dut_vec !== model_vec()) begin
          miscompares++;
          $display("FAIL drain_empty: got gnt=%b valid=%b want 0000/0", gnt, rsp_valid);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int order[8] = '{0, 1, 3, 0, 1, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
    req = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (gnt !== NUM_REQ'(1 << order[i]) || rsp_data !== 32'h100 + 32'(i) || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL rr_%0d: got gnt=%b data=%h want gnt=%b data=%h", i, gnt, rsp_data, NUM_REQ'(1 << order[i]), 32'h100 + 32'(i));
      end
    end
    req = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) push_word(32'h200 + 32'(i));
    vectors++;
    if (fifo_level !== LW'(8) || overflow_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL ovf_fill: got lvl=%0d ovf=%0d want 8/2", fifo_level, overflow_cnt);
    end
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (rsp_data !== 32'h200 + 32'(i) || rsp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_drain_%0d: got data=%h valid=%b want %h/1", i, rsp_data, rsp_valid, 32'h200 + 32'(i));
      end
    end
    req = '0;
    for (int i = 0; i < 8; i++) push_word(32'h300 + 32'(i));
    rnd_valid = 1'b1; rnd_data = 32'h400; req = 4'b0001;
    step();
    rnd_valid = 1'b0; req = '0;
    vectors++;
    if (fifo_level !== LW'(8) || overflow_cnt !== 16'd2 || gnt !== 4'b0001 || rsp_data !== 32'h300) begin
      miscompares++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%0d gnt=%b data=%h want 8/2/0001/300", fifo_level, overflow_cnt, gnt, rsp_data);
    end
  endtask

  task automatic test_health();
    do_reset();
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'hA5A5A5A5);
    push_word(32'hA5A5A5A5);
    vectors++;
    if (fifo_level !== LW'(4) || health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_fail: got lvl=%0d hf=%b want 4/0", fifo_level, health_fail);
    end
    push_word(32'hA5A5A5A5);
    vectors++;
    if (health_fail !== 1'b1 || retune_req !== 1'b1 || fifo_level !== LW'(0) || overflow_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL fail_detect: got hf=%b rt=%b lvl=%0d ovf=%0d want 1/1/0/0", health_fail, retune_req, fifo_level, overflow_cnt);
    end
    req = 4'b1111;
    push_word(32'h33);
    vectors++;
    if (retune_req !== 1'b0 || health_fail !== 1'b1) begin
      miscompares++;
      $display("FAIL retune_pulse: got rt=%b hf=%b want 0/1", retune_req, health_fail);
    end
    push_word(32'h44);
    step();
    vectors++;
    if (gnt !== 4'b0000 || fifo_level !== LW'(0) || overflow_cnt !== 16'd0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL blocked: got gnt=%b lvl=%0d ovf=%0d want 0000/0/0", gnt, fifo_level, overflow_cnt);
    end
    req = '0;
  endtask

  task automatic test_clear();
    push_word(32'hA5A5A5A5);
    push_word(32'hA5A5A5A5);
    health_clr = 1'b1;
    step();
    health_clr = 1'b0;
    vectors++;
    if (health_fail !== 1'b0 || retune_req !== 1'b0) begin
      miscompares++;
      $display("FAIL clear: got hf=%b rt=%b want 0/0", health_fail, retune_req);
    end
    push_word(32'hA5A5A5A5);
    vectors++;
    if (fifo_level !== LW'(1) || health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL post_clear_accept: got lvl=%0d hf=%b want 1/0", fifo_level, health_fail);
    end
    push_word(32'hA5A5A5A5);
    health_clr = 1'b1;
    push_word(32'hA5A5A5A5);
    vectors++;
    if (health_fail !== 1'b1 || retune_req !== 1'b1 || fifo_level !== LW'(0)) begin
      miscompares++;
      $display("FAIL clr_vs_fail: got hf=%b rt=%b lvl=%0d want 1/1/0", health_fail, retune_req, fifo_level);
    end
    health_clr = 1'b1;
    step();
    health_clr = 1'b0;
    vectors++;
    if (health_fail !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL final_clear: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'h500 + 32'(i));
    req = 4'b0010;
    step();
    vectors++;
    if (gnt !== 4'b0010 || rsp_data !== 32'h500) begin
      miscompares++;
      $display("FAIL mid_grant: got gnt=%b data=%h want 0010/500", gnt, rsp_data);
    end
    rst = 1'b1; rnd_valid = 1'b1; rnd_data = 32'h777;
    step();
    rst = 1'b0; rnd_valid = 1'b0; req = '0;
    vectors++;
    if (dut_vec !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL mid_reset: got %h want %h", dut_vec, {VW{1'b0}});
    end
    push_word(32'h600);
    req = 4'b1111;
    step();
    req = '0;
    vectors++;
    if (gnt !== 4'b0001 || rsp_data !== 32'h600) begin
      miscompares++;
      $display("FAIL post_reset_prio: got gnt=%b data=%h want 0001/600", gnt, rsp_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rnd_valid  = $urandom_range(0, 1) == 1;
      rnd_data   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4));
      req        = ($urandom_range(0, 2) == 0) ? NUM_REQ'($urandom) : '0;
      health_clr = ($urandom_range(0, 24) == 0);
      step();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, dut_vec, model_vec());
      end
    end
    rst = 1'b0; rnd_valid = 1'b0; req = '0; health_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_round_robin();
    test_overflow();
    test_health();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
